// File: rtl/typing_pkg.sv
// Shared letter/word geometry, FSM state encoding and the letter-slice helper
// used by the word match checker.
package typing_pkg;

    localparam int LETTER_W     = 5;
    localparam int WORD_LETTERS = 4;
    localparam int WORD_W       = LETTER_W * WORD_LETTERS;
    localparam int IDX_W        = 2;
    localparam int LETTER_MAX   = 25;

    typedef enum logic [2:0] {
        PRIME_HI = 3'd0,
        PRIME_LO = 3'd1,
        LOAD     = 3'd2,
        TYPING   = 3'd3,
        DONE_HI  = 3'd4,
        DONE_LO  = 3'd5
    } state_t;

    // Letter 0 lives in the top bits; shifting left brings letter idx to the top.
    function automatic logic [LETTER_W-1:0] letter_slice(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  idx
    );
        logic [WORD_W-1:0] shifted;
        shifted      = word << (LETTER_W * int'(idx));
        letter_slice = shifted[WORD_W-1 -: LETTER_W];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count up on request until all-ones is reached.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/word_match_checker.sv
// Matches keyboard letters against the delivered word and strobes wordComplete.
// Optional backspace support is enabled by defining WORD_MATCH_BACKSPACE_EN.
module word_match_checker
    import typing_pkg::*;
#(
    parameter int ERR_W        = 8,
    parameter int SCORE_W      = 10,
    parameter int PRIME_PULSES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   currentWord,
    input  logic                key_valid,
    input  logic [LETTER_W-1:0] key_code,
    input  logic                key_bksp,
    output logic                wordComplete,
    output logic                ready,
    output logic [IDX_W-1:0]    letter_index,
    output logic [LETTER_W-1:0] expected_letter,
    output logic                key_ok,
    output logic                key_err,
    output logic [ERR_W-1:0]    error_count,
    output logic [SCORE_W-1:0]  score
);

    localparam int PW = $clog2(PRIME_PULSES + 1);

    state_t              r_state;
    logic [PW-1:0]       r_prime_cnt;
    logic [WORD_W-1:0]   r_word;
    logic [IDX_W-1:0]    r_idx;
    logic [LETTER_W-1:0] r_expected;
    logic                r_wc;
    logic                r_ready;
    logic                r_key_ok;
    logic                r_key_err;

    state_t              w_state_next;
    logic [PW-1:0]       w_prime_next;
    logic [WORD_W-1:0]   w_word_next;
    logic [IDX_W-1:0]    w_idx_next;
    logic                w_wc_next;
    logic                w_ok_next;
    logic                w_err_next;
    logic                w_score_inc;
    logic                w_is_letter;
    logic                w_unused_bksp;

    assign w_is_letter = (key_code <= LETTER_W'(LETTER_MAX));

    // Next-state and pulse decode; every action lands in a register next edge.
    always_comb begin
        w_state_next = r_state;
        w_prime_next = r_prime_cnt;
        w_word_next  = r_word;
        w_idx_next   = r_idx;
        w_wc_next    = 1'b0;
        w_ok_next    = 1'b0;
        w_err_next   = 1'b0;
        w_score_inc  = 1'b0;
        case (r_state)
            PRIME_HI: begin
                w_wc_next    = 1'b1;
                w_state_next = PRIME_LO;
            end
            PRIME_LO: begin
                w_prime_next = r_prime_cnt + PW'(1);
                if (r_prime_cnt == PW'(PRIME_PULSES - 1)) begin
                    w_state_next = LOAD;
                end else begin
                    w_state_next = PRIME_HI;
                end
            end
            LOAD: begin
                w_word_next  = currentWord;
                w_idx_next   = {IDX_W{1'b0}};
                w_state_next = TYPING;
            end
            TYPING: begin
                if (key_valid) begin
                    if (!w_is_letter) begin
                        w_ok_next = 1'b0;
                    end else if (key_code == r_expected) begin
                        w_ok_next = 1'b1;
                        if (r_idx == IDX_W'(WORD_LETTERS - 1)) begin
                            w_state_next = DONE_HI;
                        end else begin
                            w_idx_next = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_err_next = 1'b1;
                    end
`ifdef WORD_MATCH_BACKSPACE_EN
                end else if (key_bksp && (r_idx != {IDX_W{1'b0}})) begin
                    w_idx_next = r_idx - IDX_W'(1);
`endif
                end else begin
                    w_idx_next = r_idx;
                end
            end
            DONE_HI: begin
                w_wc_next    = 1'b1;
                w_score_inc  = 1'b1;
                w_state_next = DONE_LO;
            end
            DONE_LO: begin
                w_state_next = LOAD;
            end
            default: begin
                w_state_next = PRIME_HI;
            end
        endcase
    end

    // Without backspace support the strobe is intentionally left unconnected.
    assign w_unused_bksp = key_bksp;

    // State, latched word and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= PRIME_HI;
            r_prime_cnt <= {PW{1'b0}};
            r_word      <= {WORD_W{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_expected  <= {LETTER_W{1'b0}};
            r_wc        <= 1'b0;
            r_ready     <= 1'b0;
            r_key_ok    <= 1'b0;
            r_key_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prime_cnt <= w_prime_next;
            r_word      <= w_word_next;
            r_idx       <= w_idx_next;
            r_expected  <= letter_slice(w_word_next, w_idx_next);
            r_wc        <= w_wc_next;
            r_ready     <= (w_state_next == TYPING);
            r_key_ok    <= w_ok_next;
            r_key_err   <= w_err_next;
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_err_next),
        .o_count (error_count)
    );

    sat_counter #(.WIDTH(SCORE_W)) u_score_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_score_inc),
        .o_count (score)
    );

    assign wordComplete    = r_wc;
    assign ready           = r_ready;
    assign letter_index    = r_idx;
    assign expected_letter = r_expected;
    assign key_ok          = r_key_ok;
    assign key_err         = r_key_err;

endmodule

// File: tb/tb_word_match_checker.sv
// Directed bench for word_match_checker: an edge-scheduled reference model is
// compared every cycle, plus literal checkpoints from the test plan.
module tb_word_match_checker;

    logic        clk;
    logic        reset;
    logic [19:0] currentWord;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_bksp;
    logic        wordComplete;
    logic        ready;
    logic [1:0]  letter_index;
    logic [4:0]  expected_letter;
    logic        key_ok;
    logic        key_err;
    logic [7:0]  error_count;
    logic [9:0]  score;

    word_match_checker dut (
        .clk             (clk),
        .reset           (reset),
        .currentWord     (currentWord),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .key_bksp        (key_bksp),
        .wordComplete    (wordComplete),
        .ready           (ready),
        .letter_index    (letter_index),
        .expected_letter (expected_letter),
        .key_ok          (key_ok),
        .key_err         (key_err),
        .error_count     (error_count),
        .score           (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [19:0] W1 = 20'b00001_10010_00000_10111;   // 1,18,0,23
    localparam logic [19:0] W2 = {5'd2, 5'd25, 5'd7, 5'd13};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Counts edges since reset release; word-level events are scheduled by edge number.
    int       m_e;
    int       m_ready_edge;
    bit       m_typing;
    int       m_word[4];
    int       m_pos;
    int       m_err;
    int       m_score;
    int       wc_q[$];
    int       sc_q[$];
    bit       m_active = 1'b0;
    int       e_wc, e_ready, e_idx, e_exp, e_ok, e_err, e_errc, e_score;

    function automatic void m_reset();
        m_e          = 0;
        m_ready_edge = 2 * 2 + 1;
        m_typing     = 1'b0;
        for (int i = 0; i < 4; i++) m_word[i] = 0;
        m_pos   = 0;
        m_err   = 0;
        m_score = 0;
        wc_q.delete();
        sc_q.delete();
        for (int i = 0; i < 2; i++) wc_q.push_back(2 * i + 1);
    endfunction

    always @(posedge clk) begin
        m_active = 1'b1;
        e_ok  = 0;
        e_err = 0;
        if (reset) begin
            m_reset();
        end else begin
            m_e++;
            if (m_typing) begin
                if (key_valid) begin
                    if (int'(key_code) <= 25) begin
                        if (int'(key_code) == m_word[m_pos]) begin
                            e_ok = 1;
                            if (m_pos == 3) begin
                                m_typing = 1'b0;
                                wc_q.push_back(m_e + 1);
                                sc_q.push_back(m_e + 1);
                                m_ready_edge = m_e + 3;
                            end else begin
                                m_pos++;
                            end
                        end else begin
                            e_err = 1;
                            if (m_err < 255) m_err++;
                        end
                    end
                end
`ifdef WORD_MATCH_BACKSPACE_EN
                else if (key_bksp && m_pos > 0) m_pos--;
`endif
            end else if (m_e == m_ready_edge) begin
                m_typing = 1'b1;
                m_pos    = 0;
                for (int i = 0; i < 4; i++) m_word[i] = int'(currentWord[19 - 5*i -: 5]);
            end
        end
        e_wc = 0;
        if (wc_q.size() > 0 && wc_q[0] == m_e && !reset) begin
            e_wc = 1;
            void'(wc_q.pop_front());
        end
        if (sc_q.size() > 0 && sc_q[0] == m_e && !reset) begin
            void'(sc_q.pop_front());
            if (m_score < 1023) m_score++;
        end
        e_ready = (m_typing && !reset) ? 1 : 0;
        e_idx   = m_pos;
        e_exp   = m_word[m_pos];
        e_errc  = m_err;
        e_score = m_score;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_active) begin
            chk("wordComplete",    int'(wordComplete),    e_wc);
            chk("ready",           int'(ready),           e_ready);
            chk("letter_index",    int'(letter_index),    e_idx);
            chk("expected_letter", int'(expected_letter), e_exp);
            chk("key_ok",          int'(key_ok),          e_ok);
            chk("key_err",         int'(key_err),         e_err);
            chk("error_count",     int'(error_count),     e_errc);
            chk("score",           int'(score),           e_score);
        end
    end

    // ---------------- stimulus ----------------
    task automatic key(input int code);
        key_valid = 1'b1;
        key_code  = 5'(code);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic bksp();
        key_bksp = 1'b1;
        @(negedge clk);
        key_bksp = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 5'd0;
        key_bksp    = 1'b0;
        currentWord = W1;
        repeat (2) @(negedge clk);
        chk("rst_wc", int'(wordComplete), 0);
        chk("rst_ready", int'(ready), 0);
        reset = 1'b0;

        // Priming: two one-high/one-low pulses, then LOAD, then TYPING.
        @(negedge clk); chk("prime1_hi", int'(wordComplete), 1);
        @(negedge clk); chk("prime1_lo", int'(wordComplete), 0);
        @(negedge clk); chk("prime2_hi", int'(wordComplete), 1);
        @(negedge clk); chk("prime2_lo_ready", int'(ready), 0);
        @(negedge clk); chk("ready_5th", int'(ready), 1);
        chk("idx_after_load", int'(letter_index), 0);
        chk("exp_after_load", int'(expected_letter), 1);

        // Clean word.
        key(1);  chk("t2_ok1", int'(key_ok), 1);
        key(18); key(0);
        key(23); chk("t2_ok_last", int'(key_ok), 1);
        chk("t2_wc_not_yet", int'(wordComplete), 0);
        @(negedge clk); chk("t2_wc", int'(wordComplete), 1); chk("t2_score", int'(score), 1);
        @(negedge clk); chk("t2_wc_gap", int'(wordComplete), 0);
        @(negedge clk); chk("t2_ready_3cyc", int'(ready), 1);

        // One wrong key.
        key(1);
        key(5);  chk("t3_err", int'(key_err), 1);
        chk("t3_errc", int'(error_count), 1); chk("t3_idx_hold", int'(letter_index), 1);
        key(18); key(0); key(23);
        repeat (3) @(negedge clk);
        chk("t3_score", int'(score), 2);

        // Non-letter in TYPING and a key during DONE_LO.
        key(27); chk("t4_nl_ok", int'(key_ok), 0); chk("t4_nl_err", int'(key_err), 0);
        key(1); key(18); key(0); key(23);
        @(negedge clk);
        key(1);  chk("t4_done_ok", int'(key_ok), 0); chk("t4_done_err", int'(key_err), 0);
        chk("t4_errc", int'(error_count), 1);
        @(negedge clk); chk("t4_score", int'(score), 3);

        // Error counter saturation.
        key_valid = 1'b1;
        key_code  = 5'd2;
        repeat (260) @(negedge clk);
        key_valid = 1'b0;
        chk("t5_sat", int'(error_count), 255);
        key(2); chk("t5_err_pulse", int'(key_err), 1); chk("t5_sat_hold", int'(error_count), 255);

        // Word changes under the latch; the next LOAD picks up W2.
        currentWord = W2;
        key(1); key(18); key(0); key(23);
        repeat (3) @(negedge clk);
        chk("t6_w2_exp", int'(expected_letter), 2);

        // Backspace, and key_valid winning over simultaneous backspace.
        key(2); key(25);
        bksp();
`ifdef WORD_MATCH_BACKSPACE_EN
        chk("t7_bksp_idx", int'(letter_index), 1);
        key(25); chk("t7_rekey_idx", int'(letter_index), 2);
`else
        chk("t7_bksp_ignored", int'(letter_index), 2);
        key(25); chk("t7_wrong_key", int'(key_err), 1);
`endif
        key_valid = 1'b1; key_bksp = 1'b1; key_code = 5'd7;
        @(negedge clk);
        key_valid = 1'b0; key_bksp = 1'b0;
        chk("t7_valid_wins", int'(letter_index), 3);
        key(13);
        @(negedge clk); chk("t7_wc", int'(wordComplete), 1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a word.
        key(2);
        reset = 1'b1;
        @(negedge clk);
        chk("t8_rst_idx", int'(letter_index), 0); chk("t8_rst_score", int'(score), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t8_ready_again", int'(ready), 1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
